// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits (LSB first), optional parity,
// 1 or 2 stop bits. Each bit lasts CLKS_PER_BIT clock cycles.
// Optional input FIFO is enabled by defining UART_TX_FIFO_EN; without it, enable is only
// honoured while idle.
module uart_tx_param #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] dout,
    output logic                 busy,
    output logic                 full,
    output logic                 done,
    output logic                 tx
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    // Reject illegal configurations at elaboration time.
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("DATA_BITS must be 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("CLKS_PER_BIT must be >= 2");
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2, >= 2");
    end

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 tx_q, tx_d;

    logic                 bit_end;
    logic                 frame_end;
    logic                 fifo_avail;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 par_bit;

    assign bit_end   = (cnt_q == CNT_LAST);
    assign frame_end = (state_q == StStop) && bit_end && (stop_q == STOP_LAST);

`ifdef UART_TX_FIFO_EN
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [PW:0]          count_q;
    logic                 push, pop;

    assign fifo_avail = (count_q != '0);
    assign fifo_head  = mem[rd_ptr_q];
    assign full       = (count_q == (PW + 1)'(FIFO_DEPTH));
    // Idle with an empty FIFO bypasses straight into the frame register.
    assign push       = enable && !full && !((state_q == StIdle) && !fifo_avail);
    assign pop        = fifo_avail && ((state_q == StIdle) || frame_end);
    assign busy       = (state_q != StIdle) || fifo_avail;

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PW + 1)'(1);
                2'b01:   count_q <= count_q - (PW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage, no reset needed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= dout;
    end
`else
    assign fifo_avail = 1'b0;
    assign fifo_head  = '0;
    assign busy       = (state_q != StIdle);
    assign full       = busy;
`endif

    assign par_bit = (PARITY == 1) ? ~^data_d : ^data_d;

    // Next-state, frame data and registered line value.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        stop_d  = stop_q;
        data_d  = data_q;
        // Registered so it lines up with the final stop-bit cycle.
        done_d  = (state_q == StStop) && (stop_q == STOP_LAST) && (cnt_q == CNT_PRE);
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (fifo_avail) begin
                    data_d  = fifo_head;
                    state_d = StStart;
                end else if (enable) begin
                    data_d  = dout;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        stop_d  = 1'b0;
                        state_d = (PARITY != 0) ? StParity : StStop;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    stop_d  = 1'b0;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (stop_q == STOP_LAST) begin
                        if (fifo_avail) begin
                            data_d  = fifo_head;
                            state_d = StStart;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        unique case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = data_d[idx_d];
            StParity: tx_d = par_bit;
            default:  tx_d = 1'b1;
        endcase
    end

    // State registers; reset aborts any frame and forces the line idle immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            data_q  <= data_d;
            done_q  <= done_d;
            tx_q    <= tx_d;
        end
    end

    assign done = done_q;
    assign tx   = tx_q;

endmodule
